// File: rtl/haar_stream_ctrl.sv
// haar_stream_ctrl: sequencing controller for the Haar filter bank.
// Accepts a valid/ready sample stream, issues single-cycle enable pulses to
// the bank with a guaranteed minimum spacing, and funnels the bank's
// per-word output strobes through a first-word-fall-through FIFO into one
// tagged valid/ready output stream.
module haar_stream_ctrl #(
  parameter int STAGES     = 4,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int EN_GAP     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WIDTH-1:0]             in_data,
  output logic                            filt_rst,
  output logic                            filt_en,
  output logic [IN_WIDTH-1:0]             filt_data,
  input  logic [STAGES:0]                 filt_strobes,
  input  logic [OUT_WIDTH*(STAGES+1)-1:0] filt_dout,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [3:0]                      out_word,
  output logic [31:0]                     sample_cnt,
  output logic                            ovf_err,
  output logic                            multi_err
);

  localparam int NW = STAGES + 1;             // number of bank output words
  localparam int AW = $clog2(FIFO_DEPTH);     // FIFO address width
  localparam int CW = AW + 1;                 // FIFO occupancy width (0..DEPTH)
  localparam int EW = 4 + OUT_WIDTH;          // FIFO entry: {index, word}
  localparam int HW = (EN_GAP > 2) ? $clog2(EN_GAP - 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((EN_GAP > 2) ? EN_GAP - 3 : 0);
  localparam logic [NW-1:0] ONE_NW    = NW'(1);
  localparam logic [CW-1:0] DEPTH_CW  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HEADROOM  = CW'(4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EN,
    ST_HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  state_t                state_reg, state_next;
  logic [HW-1:0]         hold_cnt_reg, hold_cnt_next;
  logic [IN_WIDTH-1:0]   filt_data_reg;
  logic [31:0]           sample_cnt_reg;
  logic                  filt_rst_reg;
  logic                  ovf_err_reg;
  logic                  multi_err_reg;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW-1:0]         rd_ptr_next;
  logic [CW-1:0]         count_reg;
  logic [EW-1:0]         head_reg;

  logic [OUT_WIDTH-1:0]  word_slice [NW];
  logic [3:0]            sel_idx;
  logic [OUT_WIDTH-1:0]  sel_word;
  logic [EW-1:0]         push_entry;

  logic                  accept;
  logic                  cap_block;
  logic                  push_req;
  logic                  multi_hit;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  out_valid_int;
  logic                  ovf_hit;

  // ---------------------------------------------------------------------
  // Bank output word slices
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_slice
      assign word_slice[gi] = filt_dout[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Input handshake: room for two in-flight samples' worth of outputs
  // ---------------------------------------------------------------------
  assign in_ready = (state_reg == ST_IDLE) & ~rst & ~clr &
                    ((DEPTH_CW - count_reg) >= HEADROOM);
  assign accept   = in_valid & in_ready;

  // FSM state register and pulse-spacing counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // FSM next state and enable pulse; rst/clr force IDLE from any state
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    filt_en       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_EN;
      end
      ST_EN: begin
        filt_en       = ~rst;
        hold_cnt_next = '0;
        state_next    = (EN_GAP > 2) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) state_next = ST_IDLE;
        else hold_cnt_next = hold_cnt_reg + HW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
    if (rst || clr) begin
      state_next    = ST_IDLE;
      hold_cnt_next = '0;
    end
  end

  // Sample capture and accepted-sample counter (both survive clr)
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_data_reg  <= '0;
      sample_cnt_reg <= '0;
    end else if (accept) begin
      filt_data_reg  <= in_data;
      sample_cnt_reg <= sample_cnt_reg + 32'd1;
    end
  end

  // Bank reset follows rst/clr by one cycle
  always_ff @(posedge clk) begin
    filt_rst_reg <= rst | clr;
  end

  // ---------------------------------------------------------------------
  // Strobe capture: lowest set strobe bit wins
  // ---------------------------------------------------------------------
  // Priority select scanning from the top so the lowest set bit is last
  always_comb begin
    sel_idx  = '0;
    sel_word = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (filt_strobes[i]) begin
        sel_idx  = 4'(i);
        sel_word = word_slice[i];
      end
    end
  end

  assign cap_block  = rst | clr | filt_rst_reg;
  assign push_req   = (|filt_strobes) & ~cap_block;
  assign multi_hit  = push_req & (|(filt_strobes & (filt_strobes - ONE_NW)));
  assign push_entry = {sel_idx, sel_word};

  // ---------------------------------------------------------------------
  // Output FIFO (first-word-fall-through via a registered head entry)
  // ---------------------------------------------------------------------
  assign full          = (count_reg == DEPTH_CW);
  assign out_valid_int = (count_reg != '0) & ~rst;
  assign pop           = out_valid_int & out_ready;
  assign push          = push_req & (~full | pop);
  assign ovf_hit       = push_req & full & ~pop;
  assign rd_ptr_next   = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

  // Storage array: write port only, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_entry;
  end

  // Pointers, occupancy and head register; a write landing on the next
  // head slot is forwarded so a push into an empty FIFO shows next cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && (wr_ptr_reg == rd_ptr_next)) head_reg <= push_entry;
      else head_reg <= mem[rd_ptr_next];
    end
  end

  // Sticky error flags, cleared by rst or clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_err_reg   <= 1'b0;
      multi_err_reg <= 1'b0;
    end else begin
      if (ovf_hit)   ovf_err_reg   <= 1'b1;
      if (multi_hit) multi_err_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: held at reset values during the rst cycle itself
  // ---------------------------------------------------------------------
  assign filt_rst   = filt_rst_reg;
  assign filt_data  = rst ? '0 : filt_data_reg;
  assign sample_cnt = rst ? '0 : sample_cnt_reg;
  assign out_valid  = out_valid_int;
  assign out_data   = rst ? '0 : head_reg[OUT_WIDTH-1:0];
  assign out_word   = rst ? '0 : head_reg[EW-1 -: 4];
  assign ovf_err    = ovf_err_reg & ~rst;
  assign multi_err  = multi_err_reg & ~rst;

endmodule

// File: tb/tb_haar_stream_ctrl.sv
// Directed bench for haar_stream_ctrl: a mock bank drives strobes/words
// directly; a second instance with EN_GAP=5 checks long pulse spacing.
module tb_haar_stream_ctrl;

  localparam int STAGES = 4;
  localparam int NW     = STAGES + 1;
  localparam int IW     = 16;
  localparam int OW     = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   in_data = '0;
  logic            filt_rst, filt_en;
  logic [IW-1:0]   filt_data;
  logic [NW-1:0]   filt_strobes = '0;
  logic [OW*NW-1:0] filt_dout = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OW-1:0]   out_data;
  logic [3:0]      out_word;
  logic [31:0]     sample_cnt;
  logic            ovf_err, multi_err;

  // second instance (EN_GAP=5)
  logic            in_valid5 = 1'b0;
  logic            in_ready5;
  logic            filt_rst5, filt_en5;
  logic [IW-1:0]   filt_data5;
  logic [NW-1:0]   filt_strobes5 = '0;
  logic [OW*NW-1:0] filt_dout5 = '0;
  logic            out_valid5;
  logic            out_ready5 = 1'b1;
  logic [OW-1:0]   out_data5;
  logic [3:0]      out_word5;
  logic [31:0]     sample_cnt5;
  logic            ovf_err5, multi_err5;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  haar_stream_ctrl #(.STAGES(STAGES), .IN_WIDTH(IW), .OUT_WIDTH(OW),
                     .EN_GAP(2), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .filt_rst(filt_rst), .filt_en(filt_en), .filt_data(filt_data),
    .filt_strobes(filt_strobes), .filt_dout(filt_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_word(out_word),
    .sample_cnt(sample_cnt), .ovf_err(ovf_err), .multi_err(multi_err)
  );

  haar_stream_ctrl #(.STAGES(STAGES), .IN_WIDTH(IW), .OUT_WIDTH(OW),
                     .EN_GAP(5), .FIFO_DEPTH(16)) u_gap5 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data),
    .filt_rst(filt_rst5), .filt_en(filt_en5), .filt_data(filt_data5),
    .filt_strobes(filt_strobes5), .filt_dout(filt_dout5),
    .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .out_word(out_word5),
    .sample_cnt(sample_cnt5), .ovf_err(ovf_err5), .multi_err(multi_err5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [NW-1:0] s, input logic [OW-1:0] w);
    filt_strobes = s;
    filt_dout    = {NW{w}};
  endtask

  initial begin
    int last;
    int pulses;
    logic [OW-1:0] exp_seq [8];

    // ---- reset state ----
    tick();
    chk("rst_filt_rst", filt_rst, 1);
    chk("rst_filt_en", filt_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_errs", {ovf_err, multi_err}, 0);
    rst = 1'b0;
    tick();
    chk("rel_filt_rst", filt_rst, 0);
    chk("rel_in_ready", in_ready, 1);

    // ---- enable pulses every 2 clk under continuous in_valid ----
    in_valid = 1'b1; in_data = 16'h0100;
    tick();
    chk("en1", filt_en, 1);
    chk("en1_data", filt_data, 16'h0100);
    chk("en1_cnt", sample_cnt, 1);
    chk("en1_busy", in_ready, 0);
    in_data = 16'h0200;
    tick();
    chk("gap_lo", filt_en, 0);
    chk("gap_ready", in_ready, 1);
    tick();
    chk("en2", filt_en, 1);
    chk("en2_data", filt_data, 16'h0200);
    chk("en2_cnt", sample_cnt, 2);
    in_valid = 1'b0;
    tick();
    chk("en_off1", filt_en, 0);
    tick();
    chk("en_off2", filt_en, 0);
    chk("data_hold", filt_data, 16'h0200);

    // ---- capture and ordered drain ----
    strobe(5'b10000, 16'hAAAA);
    tick();
    chk("cap1_valid", out_valid, 1);
    chk("cap1_word", out_word, 4);
    chk("cap1_data", out_data, 16'hAAAA);
    strobe(5'b01000, 16'hBBBB);
    tick();
    strobe(5'b00001, 16'hCCCC);
    tick();
    strobe('0, '0);
    out_ready = 1'b1;
    chk("head_keep", out_data, 16'hAAAA);
    tick();
    chk("pop1_word", out_word, 3);
    chk("pop1_data", out_data, 16'hBBBB);
    tick();
    chk("pop2_word", out_word, 0);
    chk("pop2_data", out_data, 16'hCCCC);
    tick();
    chk("drained", out_valid, 0);

    // ---- multiple strobes: lowest wins, multi_err sticky ----
    filt_strobes = 5'b00110;
    filt_dout    = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    tick();
    strobe('0, '0);
    chk("multi_valid", out_valid, 1);
    chk("multi_word", out_word, 1);
    chk("multi_data", out_data, 16'h1111);
    chk("multi_err", multi_err, 1);
    tick();
    chk("multi_single", out_valid, 0);
    chk("multi_sticky", multi_err, 1);

    // ---- headroom, full, overflow drop, push+pop on full ----
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(NW'(1) << (i % 5), 16'h5000 + 16'(i));
      tick();
      chk($sformatf("headroom%0d", i), in_ready, (i < 4) ? 1 : 0);
    end
    chk("full_no_ovf", ovf_err, 0);
    strobe(NW'(1) << 3, 16'h5008);
    tick();
    chk("ovf_set", ovf_err, 1);
    chk("full_head", out_data, 16'h5000);
    strobe(NW'(1) << 4, 16'h5009);
    out_ready = 1'b1;
    tick();
    strobe('0, '0);
    exp_seq = '{16'h5001, 16'h5002, 16'h5003, 16'h5004,
                16'h5005, 16'h5006, 16'h5007, 16'h5009};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_data", i), out_data, exp_seq[i]);
      chk($sformatf("drain%0d_word", i), out_word, 4'((exp_seq[i] - 16'h5000) % 5));
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("ovf_sticky", ovf_err, 1);

    // ---- clr the cycle after EN ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0300;
    strobe(5'b10000, 16'h7777);
    tick();
    chk("clr_pre_en", filt_en, 1);
    chk("clr_pre_cnt", sample_cnt, 3);
    chk("clr_pre_valid", out_valid, 1);
    in_valid = 1'b0;
    strobe('0, '0);
    tick();
    clr = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 0);
    tick();
    chk("clr_valid", out_valid, 0);
    chk("clr_en", filt_en, 0);
    chk("clr_errs", {ovf_err, multi_err}, 0);
    chk("clr_filt_rst", filt_rst, 1);
    chk("clr_cnt_kept", sample_cnt, 3);
    chk("clr_data_kept", filt_data, 16'h0300);
    clr = 1'b0;
    strobe(5'b00001, 16'h9999);
    #1;
    chk("clr_ready_back", in_ready, 1);
    tick();
    strobe('0, '0);
    chk("clr_filt_rst_end", filt_rst, 0);
    chk("clr_strobe_ignored", out_valid, 0);

    // ---- EN_GAP=5 spacing and filt_data stability ----
    in_data = 16'h3FFF;
    in_valid5 = 1'b1;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      in_data = 16'h4000 + 16'(c);
      if (filt_en5) begin
        if (last >= 0) chk($sformatf("gap5_at%0d", c), c - last, 5);
        last = c;
        pulses++;
      end
      if (last >= 0) chk($sformatf("gap5_data%0d", c), filt_data5, 16'h4000 + 16'(last) - 16'd1);
    end
    chk("gap5_pulses", pulses, 6);
    in_valid5 = 1'b0;

    // ---- rst mid-stream with 3 words queued ----
    out_ready = 1'b0;
    strobe(5'b00011, 16'h8880);
    tick();
    strobe(5'b00100, 16'h8882);
    tick();
    strobe(5'b01000, 16'h8883);
    tick();
    strobe('0, '0);
    chk("q3_valid", out_valid, 1);
    chk("q3_data", out_data, 16'h8880);
    chk("q3_multi", multi_err, 1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_valid", out_valid, 0);
    tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_word", out_word, 0);
    chk("rst_mid_cnt", sample_cnt, 0);
    chk("rst_mid_fdata", filt_data, 0);
    chk("rst_mid_multi", multi_err, 0);
    chk("rst_mid_filt_rst", filt_rst, 1);
    rst = 1'b0;
    tick();
    chk("rst_end_filt_rst", filt_rst, 0);
    chk("rst_end_empty", out_valid, 0);
    chk("rst_end_ready", in_ready, 1);
    tick();
    chk("rst_end_filt_rst2", filt_rst, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
